// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one single-beat slave port among up to four masters.
// Requests are serialised through IDLE -> ISSUE -> RESP; a silent slave is aborted with m_err.
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int TIMEOUT     = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          busy
);

  localparam int PTR_W = (NUM_MASTERS > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                 state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [PTR_W-1:0]       ptr_reg, ptr_next;
  logic [PTR_W-1:0]       gidx_reg, gidx_next;
  logic [ADDR_W-1:0]      addr_reg, addr_next;
  logic [DATA_W-1:0]      wdata_reg, wdata_next;
  logic [DATA_W-1:0]      resp_reg, resp_next;
  logic                   err_reg, err_next;
  logic [3:0]             timer_reg, timer_next;

  logic [ADDR_W-1:0]      addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_arr [NUM_MASTERS];
  logic                   sel_found;
  logic [PTR_W-1:0]       sel_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Search above the last owner first, then wrap to the low indices.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!sel_found && (j > int'(ptr_reg)) && m_valid[j]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(j);
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!sel_found && (j <= int'(ptr_reg)) && m_valid[j]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(j);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    gidx_next  = gidx_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    resp_next  = resp_reg;
    err_next   = err_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next = ISSUE;
          gidx_next  = sel_idx;
          grant_next = NUM_MASTERS'(1) << sel_idx;
          addr_next  = addr_arr[sel_idx];
          wdata_next = wdata_arr[sel_idx];
          timer_next = 4'd1;
        end
      end
      ISSUE: begin
        // A ready slave takes precedence over an expiring timer.
        if (s_ready) begin
          resp_next  = s_rdata;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (timer_reg == 4'(TIMEOUT)) begin
          resp_next  = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          timer_next = timer_reg + 4'd1;
        end
      end
      RESP: begin
        ptr_next   = gidx_reg;
        grant_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= PTR_W'(NUM_MASTERS - 1);
      gidx_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      resp_reg  <= '0;
      err_reg   <= 1'b0;
      timer_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      gidx_reg  <= gidx_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      resp_reg  <= resp_next;
      err_reg   <= err_next;
      timer_reg <= timer_next;
    end
  end

  // Every output is decoded from registered state only.
  assign s_valid = (state_reg == ISSUE);
  assign s_addr  = addr_reg;
  assign s_wdata = wdata_reg;
  assign busy    = (state_reg != IDLE);
  assign grant   = grant_reg;
  assign m_ready = (state_reg == RESP) ? grant_reg : '0;
  assign m_err   = ((state_reg == RESP) && err_reg) ? grant_reg : '0;
  assign m_rdata = resp_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single access, round-robin, stall,
// timeout, ready-at-timeout boundary and reset during an in-flight request.
module tb_bus_arbiter;

  localparam int N = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] m_valid;
  logic [7:0]   m_addr;
  logic [7:0]   m_wdata;
  logic [3:0]   m_rdata;
  logic [N-1:0] m_ready;
  logic [N-1:0] m_err;
  logic         s_valid;
  logic [3:0]   s_addr;
  logic [3:0]   s_wdata;
  logic [3:0]   s_rdata;
  logic         s_ready;
  logic [N-1:0] grant;
  logic         busy;

  logic         slave_auto;
  logic         slave_rdy;
  logic [3:0]   slave_data;

  int vectors = 0;
  int errors  = 0;

  // Auto slave answers in the same cycle and echoes write data.
  assign s_ready = slave_auto ? s_valid : slave_rdy;
  assign s_rdata = slave_auto ? s_wdata : slave_data;

  bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(4), .DATA_W(4), .TIMEOUT(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    m_valid = '0; m_addr = '0; m_wdata = '0;
    slave_auto = 1'b1; slave_rdy = 1'b0; slave_data = '0;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if ({m_ready, m_err} !== 4'b0000) begin errors++; $display("FAIL reset_ready_err got=%b exp=0000", {m_ready, m_err}); end
    vectors++; if ({s_addr, s_wdata, m_rdata} !== 12'h000) begin errors++; $display("FAIL reset_data got=%h exp=000", {s_addr, s_wdata, m_rdata}); end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    m_valid = 2'b01; m_addr = 8'h0c; m_wdata = 8'h0c;
    @(negedge clk);
    vectors++; if (s_valid !== 1'b1) begin errors++; $display("FAIL single_s_valid got=%b exp=1", s_valid); end
    vectors++; if (s_addr !== 4'hc) begin errors++; $display("FAIL single_s_addr got=%h exp=c", s_addr); end
    vectors++; if (grant !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL single_grant got=%b/%b exp=01/1", grant, busy); end
    @(negedge clk);
    vectors++; if (m_ready !== 2'b01) begin errors++; $display("FAIL single_m_ready got=%b exp=01", m_ready); end
    vectors++; if (m_rdata !== 4'hc) begin errors++; $display("FAIL single_m_rdata got=%h exp=c", m_rdata); end
    vectors++; if (m_err !== 2'b00) begin errors++; $display("FAIL single_m_err got=%b exp=00", m_err); end
    $display("txn single: ready=%b rdata=%h err=%b", m_ready, m_rdata, m_err);
    m_valid = 2'b00;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL single_idle got=%b/%b exp=0/00", busy, grant); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_r;
    logic [3:0]   exp_d;
    do_reset();
    m_valid = 2'b11; m_addr = 8'h21; m_wdata = 8'h43;
    exp_d = 4'h0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0) exp_g = 2'b00;
      else exp_g = (((c - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (c % 3 == 2) ? exp_g : 2'b00;
      if (c % 3 == 2) exp_d = (exp_g == 2'b01) ? 4'h3 : 4'h4;
      vectors++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
      vectors++; if (m_ready !== exp_r) begin errors++; $display("FAIL rr_m_ready c=%0d got=%b exp=%b", c, m_ready, exp_r); end
      if (c % 3 == 2) begin
        vectors++; if (m_rdata !== exp_d) begin errors++; $display("FAIL rr_m_rdata c=%0d got=%h exp=%h", c, m_rdata, exp_d); end
        $display("txn rr c=%0d: ready=%b rdata=%h", c, m_ready, m_rdata);
      end
      if (c == 11) m_valid = 2'b00;
    end
  endtask

  task automatic test_stall();
    slave_auto = 1'b0; slave_rdy = 1'b0; slave_data = 4'h0;
    m_valid = 2'b01; m_addr = 8'h07; m_wdata = 8'h01;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vectors++; if (s_valid !== 1'b1) begin errors++; $display("FAIL stall_s_valid c=%0d got=%b exp=1", c, s_valid); end
      vectors++; if (m_ready !== 2'b00) begin errors++; $display("FAIL stall_early_ready c=%0d got=%b exp=00", c, m_ready); end
      if (c == 4) begin slave_rdy = 1'b1; slave_data = 4'h5; end
    end
    @(negedge clk);
    slave_rdy = 1'b0;
    vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL stall_s_valid_resp got=%b exp=0", s_valid); end
    vectors++; if (m_ready !== 2'b01 || m_err !== 2'b00) begin errors++; $display("FAIL stall_ready_err got=%b/%b exp=01/00", m_ready, m_err); end
    vectors++; if (m_rdata !== 4'h5) begin errors++; $display("FAIL stall_m_rdata got=%h exp=5", m_rdata); end
    $display("txn stall: ready=%b rdata=%h err=%b", m_ready, m_rdata, m_err);
    m_valid = 2'b00;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    int sv_cnt;
    sv_cnt = 0;
    slave_auto = 1'b0; slave_rdy = 1'b0; slave_data = 4'hf;
    m_valid = 2'b10; m_addr = 8'h90; m_wdata = 8'h80;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (s_valid === 1'b1) sv_cnt++;
      vectors++; if (m_ready !== 2'b00) begin errors++; $display("FAIL to_early_ready c=%0d got=%b exp=00", c, m_ready); end
    end
    vectors++; if (sv_cnt != 7) begin errors++; $display("FAIL to_s_valid_cycles got=%0d exp=7", sv_cnt); end
    vectors++; if (s_addr !== 4'h9) begin errors++; $display("FAIL to_s_addr got=%h exp=9", s_addr); end
    @(negedge clk);
    vectors++; if (s_valid !== 1'b0) begin errors++; $display("FAIL to_s_valid_after got=%b exp=0", s_valid); end
    vectors++; if (m_ready !== 2'b10 || m_err !== 2'b10) begin errors++; $display("FAIL to_ready_err got=%b/%b exp=10/10", m_ready, m_err); end
    vectors++; if (m_rdata !== 4'h0) begin errors++; $display("FAIL to_m_rdata got=%h exp=0", m_rdata); end
    $display("txn timeout: ready=%b rdata=%h err=%b", m_ready, m_rdata, m_err);
    m_valid = 2'b00;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || m_err !== 2'b00) begin errors++; $display("FAIL to_idle got=%b/%b exp=0/00", busy, m_err); end
    vectors++; if (m_rdata !== 4'h0) begin errors++; $display("FAIL to_rdata_hold got=%h exp=0", m_rdata); end
  endtask

  task automatic test_ready_at_timeout();
    slave_auto = 1'b0; slave_rdy = 1'b0; slave_data = 4'h0;
    m_valid = 2'b01; m_addr = 8'h03; m_wdata = 8'h02;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      vectors++; if (s_valid !== 1'b1) begin errors++; $display("FAIL edge_s_valid c=%0d got=%b exp=1", c, s_valid); end
      if (c == 7) begin slave_rdy = 1'b1; slave_data = 4'ha; end
    end
    @(negedge clk);
    slave_rdy = 1'b0;
    vectors++; if (m_ready !== 2'b01 || m_err !== 2'b00) begin errors++; $display("FAIL edge_ready_err got=%b/%b exp=01/00", m_ready, m_err); end
    vectors++; if (m_rdata !== 4'ha) begin errors++; $display("FAIL edge_m_rdata got=%h exp=a", m_rdata); end
    $display("txn edge: ready=%b rdata=%h err=%b", m_ready, m_rdata, m_err);
    m_valid = 2'b00;
    @(negedge clk);
    vectors++; if (m_rdata !== 4'ha || busy !== 1'b0) begin errors++; $display("FAIL edge_hold got=%h/%b exp=a/0", m_rdata, busy); end
  endtask

  task automatic test_reset_midflight();
    slave_auto = 1'b0; slave_rdy = 1'b0;
    m_valid = 2'b10; m_addr = 8'h50; m_wdata = 8'h60;
    @(negedge clk);
    vectors++; if (grant !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre_grant got=%b/%b exp=10/1", grant, busy); end
    @(negedge clk);
    rst_n = 1'b0;
    m_valid = 2'b11;
    #1;
    vectors++; if (s_valid !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_drop got=%b/%b/%b exp=0/00/0", s_valid, grant, busy); end
    @(negedge clk);
    vectors++; if (m_ready !== 2'b00) begin errors++; $display("FAIL rst_no_ready got=%b exp=00", m_ready); end
    slave_auto = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_first_grant got=%b exp=01", grant); end
    @(negedge clk);
    vectors++; if (m_ready !== 2'b01 || m_rdata !== 4'h0) begin errors++; $display("FAIL rst_after_txn got=%b/%h exp=01/0", m_ready, m_rdata); end
    $display("txn post-reset: ready=%b rdata=%h", m_ready, m_rdata);
    m_valid = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_timeout();
    test_ready_at_timeout();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
